id_ex_reg: RTL



---
 rtl/id_ex_reg.sv | 138 +++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use hazard bubble insertion
// Optional build macro ID_EX_STATS_EN adds saturating bubble/flush counters.
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_PC,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              id_RegWrite,
  input  logic              id_ALUSrc,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_Branch,
  input  logic              id_MemToReg,
  input  logic [1:0]        id_ALUop,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_PC,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_RegWrite,
  output logic              ex_ALUSrc,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_Branch,
  output logic              ex_MemToReg,
  output logic [1:0]        ex_ALUop,
  output logic              hold_if_id
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0]       stat_bubbles,
  output logic [31:0]       stat_flushes
`endif
);

  logic load_use;
  logic bubble;
  logic ctl_en;

  // Both sources compared regardless of opcode; x0 never creates a dependency.
  assign load_use = id_valid & ex_valid & ex_MemRead & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign hold_if_id = ex_stall | (load_use & ~flush);
  assign bubble     = flush | (~ex_stall & load_use);
  assign ctl_en     = id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_PC       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_ALUop    <= 2'b00;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_PC       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_ALUop    <= 2'b00;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_PC       <= id_PC;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
      // An empty ID slot must never leak control bits into EX.
      ex_RegWrite <= id_RegWrite & ctl_en;
      ex_ALUSrc   <= id_ALUSrc   & ctl_en;
      ex_MemWrite <= id_MemWrite & ctl_en;
      ex_MemRead  <= id_MemRead  & ctl_en;
      ex_Branch   <= id_Branch   & ctl_en;
      ex_MemToReg <= id_MemToReg & ctl_en;
      ex_ALUop    <= id_ALUop & {2{ctl_en}};
    end
  end

`ifdef ID_EX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bubbles <= '0;
      stat_flushes <= '0;
    end else begin
      if (flush && stat_flushes != 32'hFFFF_FFFF)
        stat_flushes <= stat_flushes + 32'd1;
      if (!flush && !ex_stall && load_use && stat_bubbles != 32'hFFFF_FFFF)
        stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule
